gate_sweep_controller: RTL and testbench

GATE_SWEEP_CONTROLLER -- requirements
Module: gate_sweep_controller

---
 rtl/gate_sweep_controller.sv | 143 ++++++++++++++
 tb/tb_gate_sweep_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_controller.sv
// Exercises a 2-input gate with the four input vectors in turn and checks each response
// against an expected truth table. Reports a mismatch count and an overall pass flag.
module gate_sweep_controller #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] exp_tt,
  input  logic       gate_c,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic [1:0] vec_idx,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] vec_idx_q, vec_idx_d;
  logic       gate_a_q, gate_a_d;
  logic       gate_b_q, gate_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       mismatch;
  logic [2:0] err_next;

  // Sweep order is 11, 00, 10, 01 as {a,b}.
  function automatic logic [1:0] vec_ab(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'b11;
      2'd1:    return 2'b00;
      2'd2:    return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    vec_idx_d = vec_idx_q;
    gate_a_d  = gate_a_q;
    gate_b_d  = gate_b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    mismatch  = (gate_c != exp_tt[{gate_a_q, gate_b_q}]);
    err_next  = err_q;
    if (mismatch && err_q != 3'd4) begin
      err_next = err_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d              = DRIVE;
          vec_idx_d            = 2'd0;
          {gate_a_d, gate_b_d} = vec_ab(2'd0);
          hold_d               = 8'd0;
          err_d                = 3'd0;
          pass_d               = 1'b0;
          busy_d               = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          // Partial error count is kept for inspection; pass is cleared.
          state_d              = IDLE;
          {gate_a_d, gate_b_d} = 2'b00;
          busy_d               = 1'b0;
          vec_idx_d            = 2'd0;
          hold_d               = 8'd0;
          pass_d               = 1'b0;
        end else if (hold_q == HOLD_LAST) begin
          err_d  = err_next;
          hold_d = 8'd0;
          if (vec_idx_q != 2'd3) begin
            vec_idx_d            = vec_idx_q + 2'd1;
            {gate_a_d, gate_b_d} = vec_ab(vec_idx_q + 2'd1);
          end else begin
            state_d              = DONE;
            done_d               = 1'b1;
            busy_d               = 1'b0;
            vec_idx_d            = 2'd0;
            {gate_a_d, gate_b_d} = 2'b00;
            pass_d               = (err_next == 3'd0);
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= 8'd0;
      vec_idx_q <= 2'd0;
      gate_a_q  <= 1'b0;
      gate_b_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      vec_idx_q <= vec_idx_d;
      gate_a_q  <= gate_a_d;
      gate_b_q  <= gate_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = busy_q;
  assign vec_idx   = vec_idx_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Bench for gate_sweep_controller: a modelled gate (truth table act_tt) answers the
// controller, and expected outputs are derived from elapsed cycles since the start edge.
module tb_gate_sweep_controller;

  localparam int H = 10;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] exp_tt;
  logic       gate_c;
  logic       gate_a;
  logic       gate_b;
  logic       busy;
  logic [1:0] vec_idx;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] act_tt;

  int n_checks = 0;
  int n_fail   = 0;

  gate_sweep_controller #(.HOLD_CYCLES(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .exp_tt    (exp_tt),
    .gate_c    (gate_c),
    .gate_a    (gate_a),
    .gate_b    (gate_b),
    .busy      (busy),
    .vec_idx   (vec_idx),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
  );

  assign gate_c = act_tt[{gate_a, gate_b}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // {a,b} code driven for vector k: 11, 00, 10, 01.
  function automatic int code_of(input int k);
    case (k)
      0:       return 3;
      1:       return 0;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  // Mismatches among the first k vectors for a gate with table act against table ex.
  function automatic int mism_upto(input logic [3:0] act, input logic [3:0] ex, input int k);
    int n = 0;
    for (int j = 0; j < k; j++) begin
      if (act[code_of(j)] !== ex[code_of(j)]) n++;
    end
    return n;
  endfunction

  task automatic chk_idle(input int ep, input int ee);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_ab",   32'({gate_a, gate_b}), 0);
    chk("idle_vec",  32'(vec_idx), 0);
    chk("idle_pass", 32'(pass), ep);
    chk("idle_err",  32'(err_count), ee);
  endtask

  task automatic chk_drive(input int t, input logic [3:0] act, input logic [3:0] ex);
    int k = t / H;
    chk("drv_busy", 32'(busy), 1);
    chk("drv_vec",  32'(vec_idx), k);
    chk("drv_ab",   32'({gate_a, gate_b}), code_of(k));
    chk("drv_done", 32'(done), 0);
    chk("drv_pass", 32'(pass), 0);
    chk("drv_err",  32'(err_count), mism_upto(act, ex, k));
  endtask

  task automatic chk_done(input int ep, input int ee);
    chk("dn_done", 32'(done), 1);
    chk("dn_busy", 32'(busy), 0);
    chk("dn_ab",   32'({gate_a, gate_b}), 0);
    chk("dn_pass", 32'(pass), ep);
    chk("dn_err",  32'(err_count), ee);
  endtask

  // Called at a negedge. poke/abort_at/rst_at are cycle offsets (t) after the start edge,
  // -1 for none; the pulse is driven during cycle t and sampled at the following edge.
  task automatic run_sweep(input logic [3:0] act, input logic [3:0] ex,
                           input int poke, input int abort_at, input int rst_at);
    int fin_err;
    int fin_pass;
    act_tt   = act;
    exp_tt   = ex;
    fin_err  = mism_upto(act, ex, 4);
    fin_pass = (fin_err == 0) ? 1 : 0;
    $display("sweep act=%b exp=%b poke=%0d abort=%0d rst=%0d expect err=%0d pass=%0d",
             act, ex, poke, abort_at, rst_at, fin_err, fin_pass);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 0; t <= 4 * H + 1; t++) begin
      @(negedge clk);
      if (t < 4 * H) chk_drive(t, act, ex);
      else if (t == 4 * H) chk_done(fin_pass, fin_err);
      else chk_idle(fin_pass, fin_err);
      start = (t == poke);
      abort = (t == abort_at);
      rst   = (t == rst_at);
      if (t == abort_at || t == rst_at) begin
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        fin_pass = 0;
        fin_err  = (t == rst_at) ? 0 : mism_upto(act, ex, t / H);
        chk_idle(fin_pass, fin_err);
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    // Quiet period: no queued restart, and abort in IDLE changes nothing.
    for (int i = 0; i < H; i++) begin
      @(negedge clk);
      chk_idle(fin_pass, fin_err);
      abort = i[0];
    end
    abort = 1'b0;
  endtask

  initial begin
    int ab;
    logic [3:0] ra;
    logic [3:0] re;
    start  = 1'b0;
    abort  = 1'b0;
    rst    = 1'b1;
    exp_tt = 4'b1000;
    act_tt = 4'b1000;
    repeat (3) @(negedge clk);
    chk_idle(0, 0);
    // Reset beats start.
    start = 1'b1;
    @(negedge clk);
    chk_idle(0, 0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    chk_idle(0, 0);

    run_sweep(4'b1000, 4'b1000, -1, -1, -1);        // ideal AND
    run_sweep(4'b0000, 4'b1000, -1, -1, -1);        // stuck at 0
    run_sweep(4'b1111, 4'b1000, -1, -1, -1);        // stuck at 1
    run_sweep(4'b1000, 4'b1000, H + 2, -1, -1);     // start during idx1 ignored
    run_sweep(4'b1000, 4'b1000, 4 * H, -1, -1);     // start during DONE ignored
    run_sweep(4'b1000, 4'b1000, -1, 2 * H + 5, -1); // abort in idx2
    run_sweep(4'b0000, 4'b1000, -1, 4 * H - 1, -1); // abort beats final compare
    run_sweep(4'b0000, 4'b1000, -1, -1, H + 3);     // reset mid idx1
    run_sweep(4'b1000, 4'b1000, -1, -1, -1);        // clean sweep after reset

    // start held high restarts from the single IDLE cycle after DONE.
    $display("sweep held-start act=1000 exp=1000");
    act_tt = 4'b1000;
    exp_tt = 4'b1000;
    start  = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= 4 * H + 2; t++) begin
      @(negedge clk);
      if (t < 4 * H) chk_drive(t, 4'b1000, 4'b1000);
      else if (t == 4 * H) chk_done(1, 0);
      else if (t == 4 * H + 1) chk_idle(1, 0);
      else chk_drive(0, 4'b1000, 4'b1000);
    end
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle(0, 0);

    for (int n = 0; n < 8; n++) begin
      ra = 4'($urandom_range(0, 15));
      re = 4'($urandom_range(0, 15));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4 * H - 1)) : -1;
      run_sweep(ra, re, int'($urandom_range(0, 4 * H)), ab, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
